// File: rtl/forward_converter_9_8_7_seq_if.sv
// Handshake bundle for the 9/8/7 forward converter: binary operand in, residue triple out.
// The master side is the operand producer and residue consumer; the slave side is the converter.
interface forward_converter_9_8_7_seq_if;
    logic [8:0] x_in;
    logic       in_valid_in;
    logic       in_ready_out;
    logic [3:0] r1_out;
    logic [2:0] r2_out;
    logic [2:0] r3_out;
    logic       out_valid_out;
    logic       out_ready_in;
    logic       busy_out;

    modport master (
        output x_in,
        output in_valid_in,
        output out_ready_in,
        input  in_ready_out,
        input  r1_out,
        input  r2_out,
        input  r3_out,
        input  out_valid_out,
        input  busy_out
    );

    modport slave (
        input  x_in,
        input  in_valid_in,
        input  out_ready_in,
        output in_ready_out,
        output r1_out,
        output r2_out,
        output r3_out,
        output out_valid_out,
        output busy_out
    );
endinterface

// File: rtl/forward_converter_9_8_7_seq.sv
// Bit-serial binary-to-RNS converter for moduli {9, 8, 7}: MSB-first Horner reduction over
// nine cycles, with registered valid/ready handshakes on both the operand and the result side.
module forward_converter_9_8_7_seq (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    forward_converter_9_8_7_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One Horner step modulo 9: acc < 9 keeps 2*acc+b <= 17, so one subtract is enough.
    function automatic logic [3:0] mod9_step(input logic [3:0] acc, input logic b);
        logic [4:0] t;
        t = {acc, b};
        if (t >= 5'd9) begin
            t = t - 5'd9;
        end else begin
            t = t;
        end
        return t[3:0];
    endfunction

    // One Horner step modulo 7: acc < 7 keeps 2*acc+b <= 13.
    function automatic logic [2:0] mod7_step(input logic [2:0] acc, input logic b);
        logic [3:0] t;
        t = {acc, b};
        if (t >= 4'd7) begin
            t = t - 4'd7;
        end else begin
            t = t;
        end
        return t[2:0];
    endfunction

    state_t     state_q,     state_d;
    logic [8:0] x_q,         x_d;
    logic [3:0] acc9_q,      acc9_d;
    logic [2:0] acc7_q,      acc7_d;
    logic [3:0] cnt_q,       cnt_d;
    logic [3:0] r1_q,        r1_d;
    logic [2:0] r2_q,        r2_d;
    logic [2:0] r3_q,        r3_d;
    logic       out_valid_q, out_valid_d;
    logic       in_ready_q,  in_ready_d;
    logic       busy_q,      busy_d;

    logic       bit_s;
    logic [3:0] acc9_next_s;
    logic [2:0] acc7_next_s;

    // Current operand bit and the reduced accumulators it produces.
    always_comb begin
        bit_s       = x_q[cnt_q];
        acc9_next_s = mod9_step(acc9_q, bit_s);
        acc7_next_s = mod7_step(acc7_q, bit_s);
    end

    // Next-state and registered-output logic; outputs are flops so the handshake is glitch-free.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        acc9_d      = acc9_q;
        acc7_d      = acc7_q;
        cnt_d       = cnt_q;
        r1_d        = r1_q;
        r2_d        = r2_q;
        r3_d        = r3_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid_in) begin
                    x_d        = bus.x_in;
                    acc9_d     = 4'd0;
                    acc7_d     = 3'd0;
                    cnt_d      = 4'd8;
                    state_d    = ST_BUSY;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end else begin
                    in_ready_d = 1'b1;
                    busy_d     = 1'b0;
                end
            end
            ST_BUSY: begin
                acc9_d = acc9_next_s;
                acc7_d = acc7_next_s;
                if (cnt_q == 4'd0) begin
                    // Mod 8 needs no iteration: it is just the three low operand bits.
                    r1_d        = acc9_next_s;
                    r2_d        = x_q[2:0];
                    r3_d        = acc7_next_s;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                if (bus.out_ready_in) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q     <= ST_IDLE;
            x_q         <= 9'd0;
            acc9_q      <= 4'd0;
            acc7_q      <= 3'd0;
            cnt_q       <= 4'd0;
            r1_q        <= 4'd0;
            r2_q        <= 3'd0;
            r3_q        <= 3'd0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            acc9_q      <= acc9_d;
            acc7_q      <= acc7_d;
            cnt_q       <= cnt_d;
            r1_q        <= r1_d;
            r2_q        <= r2_d;
            r3_q        <= r3_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready_out  = in_ready_q;
    assign bus.out_valid_out = out_valid_q;
    assign bus.busy_out      = busy_q;
    assign bus.r1_out        = r1_q;
    assign bus.r2_out        = r2_q;
    assign bus.r3_out        = r3_q;

    forward_converter_9_8_7_seq_chk u_chk (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .in_ready   (in_ready_q),
        .out_valid  (out_valid_q),
        .busy       (busy_q)
    );

endmodule

// Handshake invariants: a result is only offered while busy, and input is never accepted while busy.
module forward_converter_9_8_7_seq_chk (
    input logic clk_in,
    input logic rst_n_in,
    input logic in_ready,
    input logic out_valid,
    input logic busy
);
    valid_implies_busy: assert property (@(posedge clk_in) disable iff (!rst_n_in) out_valid |-> busy);
    ready_excludes_busy: assert property (@(posedge clk_in) disable iff (!rst_n_in) in_ready |-> !busy);
endmodule

// File: tb/tb_forward_converter_9_8_7_seq.sv
// Scoreboard bench for the 9/8/7 forward converter: a driver queues expected residues per accepted
// operand, and an independent monitor checks every delivered triple, its latency and CRT round trip.
module tb_forward_converter_9_8_7_seq;

    logic clk;
    logic rst_n;

    forward_converter_9_8_7_seq_if bus ();

    forward_converter_9_8_7_seq dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    typedef struct {
        int r1;
        int r2;
        int r3;
        int x;
        bit crt;
        int acc_cyc;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   rise_cyc = 0;
    int   last_acc = -1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Inverse mapping for moduli {9,8,7}, M=504: weights 280, 441, 288.
    function automatic int crt(input int r1, input int r2, input int r3);
        return (280 * r1 + 441 * r2 + 288 * r3) % 504;
    endfunction

    // Monitor: pops one expectation per output handshake.
    initial begin
        exp_t e;
        bit   prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.out_valid_out === 1'b1 && !prev_valid) begin
                rise_cyc = cyc;
            end
            if (rst_n === 1'b1 && bus.out_valid_out === 1'b1 && bus.out_ready_in === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    e = q.pop_front();
                    if (e.crt) begin
                        chk("round_trip", crt(int'(bus.r1_out), int'(bus.r2_out), int'(bus.r3_out)), e.x);
                    end else begin
                        chk("r1", int'(bus.r1_out), e.r1);
                        chk("r2", int'(bus.r2_out), e.r2);
                        chk("r3", int'(bus.r3_out), e.r3);
                    end
                    chk("latency", rise_cyc - e.acc_cyc, 9);
                end
            end
            prev_valid = (bus.out_valid_out === 1'b1);
        end
    end

    task automatic send(input int x, input int r1, input int r2, input int r3,
                        input bit use_crt, input bit push, input bit b2b);
        exp_t e;
        bit   got;
        int   acc;
        @(posedge clk);
        #1;
        bus.x_in        = x[8:0];
        bus.in_valid_in = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (bus.in_ready_out === 1'b1) got = 1'b1;
        end
        if (!got) begin
            chk("accept_timeout", 0, 1);
        end else begin
            acc = cyc + 1;
            if (push) begin
                e.r1 = r1; e.r2 = r2; e.r3 = r3; e.x = x; e.crt = use_crt; e.acc_cyc = acc;
                q.push_back(e);
            end
            if (b2b && last_acc >= 0) chk("throughput", acc - last_acc, 11);
            last_acc = acc;
        end
        @(posedge clk);
        #1;
        bus.in_valid_in = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            chk("drain_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_in_ready"},  int'(bus.in_ready_out), 1);
        chk({tag, "_out_valid"}, int'(bus.out_valid_out), 0);
        chk({tag, "_busy"},      int'(bus.busy_out), 0);
        chk({tag, "_r1"},        int'(bus.r1_out), 0);
        chk({tag, "_r2"},        int'(bus.r2_out), 0);
        chk({tag, "_r3"},        int'(bus.r3_out), 0);
    endtask

    initial begin
        bit got;
        rst_n            = 1'b0;
        bus.x_in         = 9'd0;
        bus.in_valid_in  = 1'b0;
        bus.out_ready_in = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed vectors with hand-computed residues.
        send(0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
        drain();
        @(negedge clk);
        chk("in_ready_after_handshake", int'(bus.in_ready_out), 1);
        send(503, 8, 7, 6, 1'b0, 1'b1, 1'b0); drain();
        send(257, 5, 1, 5, 1'b0, 1'b1, 1'b0); drain();
        send(100, 1, 4, 2, 1'b0, 1'b1, 1'b0); drain();
        send(511, 7, 7, 0, 1'b0, 1'b1, 1'b0); drain();
        send(7,   7, 7, 0, 1'b0, 1'b1, 1'b0); drain();

        // Backpressure: result must hold while the consumer stalls.
        @(posedge clk);
        #1;
        bus.out_ready_in = 1'b0;
        send(100, 1, 4, 2, 1'b0, 1'b1, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.out_valid_out === 1'b1) got = 1'b1;
        end
        chk("bp_valid_seen", int'(got), 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid_in = ~bus.in_valid_in;
            bus.x_in        = 9'($urandom_range(0, 511));
            @(negedge clk);
            chk("bp_out_valid", int'(bus.out_valid_out), 1);
            chk("bp_in_ready",  int'(bus.in_ready_out), 0);
            chk("bp_r1", int'(bus.r1_out), 1);
            chk("bp_r2", int'(bus.r2_out), 4);
            chk("bp_r3", int'(bus.r3_out), 2);
        end
        @(posedge clk);
        #1;
        bus.in_valid_in  = 1'b0;
        bus.out_ready_in = 1'b1;
        drain();
        @(negedge clk);
        chk("bp_release_valid", int'(bus.out_valid_out), 0);
        chk("bp_release_ready", int'(bus.in_ready_out), 1);

        // Reset during BUSY cycle 4 aborts the conversion.
        send(257, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_zero("abort");
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("abort_no_valid", int'(bus.out_valid_out), 0);
        end
        send(42, 6, 2, 0, 1'b0, 1'b1, 1'b0); drain();

        // Exhaustive round trip at full throughput.
        last_acc = -1;
        for (int x = 0; x < 504; x++) begin
            send(x, 0, 0, 0, 1'b1, 1'b1, 1'b1);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
